// File: rtl/digit_decoder.sv
`default_nettype none
// ============================================================================
// Module      : digit_decoder
// Description : Registered code-to-digit decoder. Maps the gapped 4-bit code
//               set {0x2..0x6, 0x9..0xD} onto decimal digits 0..9. Any other
//               code is flagged as illegal, and a saturating counter keeps a
//               tally of illegal codes for status/debug.
//
// Ports       : clk      - system clock, rising edge
//               rst      - synchronous active-high reset
//               C        - input code
//               c_vld    - C is valid this cycle
//               y        - decoded digit (4'b1111 on an illegal code)
//               y_vld    - y/err valid, one cycle after an accepted code
//               err      - accepted code was illegal
//               err_cnt  - saturating count of accepted illegal codes
//
// Revision    : 1.0 - initial release
// ============================================================================
module digit_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       C,
    input  logic             c_vld,
    output logic [3:0]       y,
    output logic             y_vld,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [3:0]       c_ILLEGAL_DIGIT = 4'b1111;
    localparam logic [CNT_W-1:0] c_CNT_ONE       = CNT_W'(1);

    logic [3:0]       r_y;
    logic             r_y_vld;
    logic             r_err;
    logic [CNT_W-1:0] r_err_cnt;

    logic [3:0]       w_digit;
    logic             w_legal;
    logic             w_cnt_max;

    // The legal set has a two-code hole (0x7, 0x8) in the middle, so the
    // upper run is offset by 4 instead of 2.
    always_comb begin
        w_digit = c_ILLEGAL_DIGIT;
        w_legal = 1'b0;
        case (C)
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
                w_digit = C - 4'd2;
                w_legal = 1'b1;
            end
            4'h9, 4'hA, 4'hB, 4'hC, 4'hD: begin
                w_digit = C - 4'd4;
                w_legal = 1'b1;
            end
            default: begin
                w_digit = c_ILLEGAL_DIGIT;
                w_legal = 1'b0;
            end
        endcase
    end

    assign w_cnt_max = &r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y       <= 4'b0000;
            r_y_vld   <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else if (c_vld) begin
            r_y     <= w_digit;
            r_y_vld <= 1'b1;
            r_err   <= ~w_legal;
            if (!w_legal && !w_cnt_max) begin
                r_err_cnt <= r_err_cnt + c_CNT_ONE;
            end
        end else begin
            // Idle cycle: y keeps the last digit, the strobes drop.
            r_y_vld <= 1'b0;
            r_err   <= 1'b0;
        end
    end

    assign y       = r_y;
    assign y_vld   = r_y_vld;
    assign err     = r_err;
    assign err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_digit_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_digit_decoder
// Description : Self-checking bench for digit_decoder. A default-width
//               instance and a CNT_W=2 instance share one stimulus stream;
//               expected results come from a vector table and are matched
//               through a scoreboard queue one cycle after being driven.
//
// Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_decoder;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [3:0] code;
        logic [3:0] exp_y;
        logic       exp_vld;
        logic       exp_err;
        logic [7:0] exp_cnt;
        logic [1:0] exp_cnt2;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [3:0] C;
    logic       c_vld;

    logic [3:0] y_a, y_b;
    logic       y_vld_a, y_vld_b;
    logic       err_a, err_b;
    logic [7:0] err_cnt_a;
    logic [1:0] err_cnt_b;

    int n_vec  = 0;
    int n_miss = 0;

    vec_t vecs[$];
    vec_t sb[$];

    digit_decoder #(.CNT_W(8)) u_dut_a (
        .clk    (clk),
        .rst    (rst),
        .C      (C),
        .c_vld  (c_vld),
        .y      (y_a),
        .y_vld  (y_vld_a),
        .err    (err_a),
        .err_cnt(err_cnt_a)
    );

    digit_decoder #(.CNT_W(2)) u_dut_b (
        .clk    (clk),
        .rst    (rst),
        .C      (C),
        .c_vld  (c_vld),
        .y      (y_b),
        .y_vld  (y_vld_b),
        .err    (err_b),
        .err_cnt(err_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic v, input logic [3:0] c,
                                input logic [3:0] ey, input logic ev, input logic ee,
                                input logic [7:0] ec, input logic [1:0] ec2);
        vec_t t;
        t.rst = r; t.vld = v; t.code = c;
        t.exp_y = ey; t.exp_vld = ev; t.exp_err = ee;
        t.exp_cnt = ec; t.exp_cnt2 = ec2;
        return t;
    endfunction

    task automatic check(input int idx, input vec_t e);
        n_vec++;
        if (y_a !== e.exp_y) begin
            n_miss++;
            $display("FAIL vec%0d y: got %h expected %h", idx, y_a, e.exp_y);
        end
        if (y_vld_a !== e.exp_vld) begin
            n_miss++;
            $display("FAIL vec%0d y_vld: got %b expected %b", idx, y_vld_a, e.exp_vld);
        end
        if (err_a !== e.exp_err) begin
            n_miss++;
            $display("FAIL vec%0d err: got %b expected %b", idx, err_a, e.exp_err);
        end
        if (err_cnt_a !== e.exp_cnt) begin
            n_miss++;
            $display("FAIL vec%0d err_cnt: got %0d expected %0d", idx, err_cnt_a, e.exp_cnt);
        end
        if (y_b !== e.exp_y || y_vld_b !== e.exp_vld || err_b !== e.exp_err) begin
            n_miss++;
            $display("FAIL vec%0d narrow outs: got y=%h v=%b e=%b expected y=%h v=%b e=%b",
                     idx, y_b, y_vld_b, err_b, e.exp_y, e.exp_vld, e.exp_err);
        end
        if (err_cnt_b !== e.exp_cnt2) begin
            n_miss++;
            $display("FAIL vec%0d err_cnt(W=2): got %0d expected %0d", idx, err_cnt_b, e.exp_cnt2);
        end
    endtask

    initial begin
        // Reset held two cycles with a legal code presented.
        vecs.push_back(mk(1, 1, 4'hD, 4'h0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 4'hD, 4'h0, 0, 0, 0, 0));
        // Full legal sweep.
        vecs.push_back(mk(0, 1, 4'hD, 4'd9, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4'hC, 4'd8, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4'hB, 4'd7, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4'hA, 4'd6, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4'h9, 4'd5, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4'h2, 4'd0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4'h3, 4'd1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4'h4, 4'd2, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4'h5, 4'd3, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4'h6, 4'd4, 1, 0, 0, 0));
        // Illegal codes back-to-back; narrow counter saturates at 3.
        vecs.push_back(mk(0, 1, 4'h0, 4'hF, 1, 1, 1, 1));
        vecs.push_back(mk(0, 1, 4'h1, 4'hF, 1, 1, 2, 2));
        vecs.push_back(mk(0, 1, 4'h7, 4'hF, 1, 1, 3, 3));
        vecs.push_back(mk(0, 1, 4'h8, 4'hF, 1, 1, 4, 3));
        vecs.push_back(mk(0, 1, 4'hE, 4'hF, 1, 1, 5, 3));
        vecs.push_back(mk(0, 1, 4'hF, 4'hF, 1, 1, 6, 3));
        // Legal code then a 3-cycle gap with junk on C.
        vecs.push_back(mk(0, 1, 4'h5, 4'd3, 1, 0, 6, 3));
        vecs.push_back(mk(0, 0, 4'hE, 4'd3, 0, 0, 6, 3));
        vecs.push_back(mk(0, 0, 4'h1, 4'd3, 0, 0, 6, 3));
        vecs.push_back(mk(0, 0, 4'h7, 4'd3, 0, 0, 6, 3));
        // Three illegal codes, then reset with an illegal code presented.
        vecs.push_back(mk(0, 1, 4'h0, 4'hF, 1, 1, 7, 3));
        vecs.push_back(mk(0, 1, 4'hE, 4'hF, 1, 1, 8, 3));
        vecs.push_back(mk(0, 1, 4'h8, 4'hF, 1, 1, 9, 3));
        vecs.push_back(mk(1, 1, 4'h7, 4'h0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4'h9, 4'd5, 1, 0, 0, 0));
        // Saturation from zero: narrow counter 1,2,3,3,3.
        vecs.push_back(mk(0, 1, 4'h7, 4'hF, 1, 1, 1, 1));
        vecs.push_back(mk(0, 1, 4'h1, 4'hF, 1, 1, 2, 2));
        vecs.push_back(mk(0, 1, 4'hF, 4'hF, 1, 1, 3, 3));
        vecs.push_back(mk(0, 1, 4'h0, 4'hF, 1, 1, 4, 3));
        vecs.push_back(mk(0, 1, 4'h8, 4'hF, 1, 1, 5, 3));
        // Idle after an illegal code: y holds 4'b1111, strobes drop.
        vecs.push_back(mk(0, 0, 4'h3, 4'hF, 0, 0, 5, 3));
        vecs.push_back(mk(0, 1, 4'hC, 4'd8, 1, 0, 5, 3));

        rst   = 1'b1;
        c_vld = 1'b0;
        C     = 4'h0;
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t e;
            rst   = vecs[i].rst;
            c_vld = vecs[i].vld;
            C     = vecs[i].code;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                n_miss++;
                $display("FAIL vec%0d scoreboard: got empty queue expected entry", i);
            end else begin
                e = sb.pop_front();
                check(i, e);
            end
        end

        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard drain: got %0d leftover expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
